// File: rtl/can_tx_scheduler_if.sv
// rtl/can_tx_scheduler_if.sv - requester and frame-generator signal bundle for can_tx_scheduler
interface can_tx_scheduler_if #(
  parameter int NREQ = 4
);
  logic                 arb_mode;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*76-1:0]   req_payload;
  logic [NREQ-1:0]      req_ready;
  logic [75:0]          gen_payload;
  logic                 gen_start;
  logic                 gen_done;
  logic                 tx_done;
  logic [2:0]           tx_idx;
  logic                 timeout_err;
  logic                 busy;

  modport master (
    output arb_mode, req_valid, req_payload, gen_done,
    input  req_ready, gen_payload, gen_start, tx_done, tx_idx, timeout_err, busy
  );

  modport slave (
    input  arb_mode, req_valid, req_payload, gen_done,
    output req_ready, gen_payload, gen_start, tx_done, tx_idx, timeout_err, busy
  );
endinterface

// File: rtl/can_tx_scheduler.sv
// rtl/can_tx_scheduler.sv - arbitrates NREQ requesters onto one CAN frame generator
// CAN-ID priority or round-robin grant, generator timeout and inter-frame spacing.
module can_tx_scheduler #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int IFS_CYC     = 3
) (
  input  logic              clk,
  input  logic              rst,
  can_tx_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, IFS} state_t;

  localparam logic [15:0] TO_LIM  = 16'(TIMEOUT_CYC);
  localparam logic [7:0]  IFS_LEN = (IFS_CYC == 0) ? 8'd1 : 8'(IFS_CYC);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_inc;
  logic [7:0]  ifs_cnt;
  logic [2:0]  rr_ptr;
  logic        grant_ok;
  logic [2:0]  grant;
  logic [10:0] best_id;
  logic [75:0] grant_payload;
  logic [75:0] pay_q;
  logic [2:0]  idx_q;
  logic        tx_done_q;
  logic        timeout_q;
  logic        timeout_hit;
  logic        ifs_last;

  assign wait_inc    = wait_cnt + 16'd1;
  assign timeout_hit = (wait_inc == TO_LIM);
  assign ifs_last    = ((ifs_cnt + 8'd1) == IFS_LEN);

  always_comb begin
    grant_ok      = 1'b0;
    grant         = '0;
    best_id       = '1;
    grant_payload = '0;
    if (!bus.arb_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && (!grant_ok || (bus.req_payload[76*i+64 +: 11] < best_id))) begin
          grant_ok      = 1'b1;
          grant         = 3'(i);
          best_id       = bus.req_payload[76*i+64 +: 11];
          grant_payload = bus.req_payload[76*i +: 76];
        end
      end
    end else begin
      // Upper pass covers rr_ptr..NREQ-1, the lower pass wraps around to 0.
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_ok && bus.req_valid[i] && (i >= int'(rr_ptr))) begin
          grant_ok      = 1'b1;
          grant         = 3'(i);
          grant_payload = bus.req_payload[76*i +: 76];
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_ok && bus.req_valid[i]) begin
          grant_ok      = 1'b1;
          grant         = 3'(i);
          grant_payload = bus.req_payload[76*i +: 76];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_ok) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (bus.gen_done || timeout_hit) state_nxt = IFS;
      IFS:     if (ifs_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is combinational so the accept lands on the same edge that latches the payload.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = rst && (state == IDLE) && grant_ok && (grant == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pay_q     <= '0;
      idx_q     <= '0;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      ifs_cnt   <= '0;
      tx_done_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            pay_q  <= grant_payload;
            idx_q  <= grant;
            rr_ptr <= (grant == 3'(NREQ - 1)) ? 3'd0 : grant + 3'd1;
          end
        end
        START: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_inc;
          ifs_cnt  <= '0;
          if (bus.gen_done)     tx_done_q <= 1'b1;
          else if (timeout_hit) timeout_q <= 1'b1;
        end
        IFS:     ifs_cnt <= ifs_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.gen_start   = (state == START);
  assign bus.gen_payload = pay_q;
  assign bus.tx_idx      = idx_q;
  assign bus.tx_done     = tx_done_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: doc/can_tx_scheduler.md
CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one CAN frame generator (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 255: maximum cycles to wait for generator completion (1..65535).
REQ-003 Parameter IFS_CYC, default 3: idle cycles inserted after each frame (0..255).
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 arb_mode  in  1  0 = CAN-ID priority, 1 = round-robin.
REQ-007 req_valid  in  NREQ  per-requester frame pending.
REQ-008 req_payload  in  NREQ*76  per-requester payload; slice k = bits [76k+75:76k]; within a slice [74:64] = 11-bit CAN ID, [63:0] = data, [75] unused.
REQ-009 req_ready  out  NREQ  one-cycle accept pulse to the granted requester.
REQ-010 gen_payload  out  76  registered payload driven to the frame generator.
REQ-011 gen_start  out  1  one-cycle pulse that starts the frame generator.
REQ-012 gen_done  in  1  pulse from the generator when the frame has been shifted out.
REQ-013 tx_done  out  1  one-cycle pulse when a frame completes normally.
REQ-014 tx_idx  out  3  index of the last granted requester; valid with tx_done and timeout_err.
REQ-015 timeout_err  out  1  one-cycle pulse when TIMEOUT_CYC expires.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states and transitions:
- IDLE: stays in IDLE while no request is valid; moves to START when any request is valid.
- START: moves to WAIT unconditionally.
- WAIT: moves to IFS on gen_done or on timeout.
- IFS: moves to IDLE after IFS_CYC cycles; with IFS_CYC = 0, IFS lasts exactly 1 cycle.
REQ-018 Grant is evaluated combinationally in IDLE; in the same edge the block latches req_payload[g] into gen_payload, latches g into tx_idx, and pulses req_ready[g].
REQ-019 arb_mode=0: the lowest 11-bit CAN ID among valid requesters wins; ties go to the lowest index.
REQ-020 arb_mode=1: the first valid requester at or after rr_ptr (modulo NREQ) wins; after each grant rr_ptr = (g+1) mod NREQ.
REQ-021 arb_mode is sampled only in IDLE; changing it mid-frame has no effect on the current frame.
REQ-022 A requester holds req_valid and req_payload stable until its req_ready pulse; req_valid&req_ready = accepted.
REQ-023 A requester may deassert req_valid before acceptance; such a request is never granted.
REQ-024 gen_start is high for exactly the one cycle the FSM is in START; latency from the valid sample in IDLE to gen_start = 1 cycle.
REQ-025 gen_payload holds its value from grant until the next grant.
REQ-026 gen_done is ignored in IDLE, START and IFS.
REQ-027 Timeout counter:
- Width is 16 bits; it clears on entry to WAIT and increments each WAIT cycle.
- When it reaches TIMEOUT_CYC without gen_done, the block pulses timeout_err and moves to IFS.
- The accepted frame is dropped and is not retried.
REQ-028 gen_done in the same cycle the counter reaches TIMEOUT_CYC counts as success: tx_done pulses and timeout_err does not.
REQ-029 tx_done pulses in the cycle after gen_done is sampled in WAIT.
REQ-030 At most one grant is issued per frame cycle; no requester is granted while busy=1.

Reset
REQ-031 While rst=0, the following hold:
- state = IDLE;
- req_ready = 0, gen_start = 0, tx_done = 0, timeout_err = 0, busy = 0;
- gen_payload = 0, tx_idx = 0, rr_ptr = 0;
- all counters = 0.
REQ-032 Reset asserted mid-frame aborts immediately. The in-flight frame is forgotten, and the first grant after release follows REQ-019/020 with rr_ptr = 0.

Verification
REQ-033 arb_mode=0; req 1 ID 0x123 and req 3 ID 0x055 both valid -> req_ready[3] pulses, gen_payload[74:64] = 0x055, gen_start one cycle later.
REQ-034 arb_mode=1; all 4 requests held valid -> grants go 0,1,2,3,0 with IFS_CYC+1 idle cycles between frames.
REQ-035 Equal IDs 0x200 on req 0 and req 2, arb_mode=0 -> req 0 is granted first and req 2 second.
REQ-036 gen_done never returned, TIMEOUT_CYC=255 -> timeout_err pulses 255 cycles after WAIT entry, no tx_done, busy drops after IFS.
REQ-037 gen_done in the timeout cycle -> tx_done=1 and timeout_err=0.
REQ-038 rst pulled low during WAIT -> all outputs equal the reset values immediately; after release a pending req 2 (arb_mode=1) is granted with rr_ptr = 0.
